// File: rtl/uart_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_prog_loader_pkg
// Shared constants and types for the serial program loader:
//   HDR_BYTE                 frame header byte (0x5A)
//   DEFAULT_CLKS_PER_BIT     100 MHz / 9600 baud
//   IMEM_ADDR_W              instruction-memory word-address width (PC[15:2])
//   DEFAULT_TIMEOUT_CYCLES   idle cycles allowed between bytes inside a frame
//   load_state_e / rx_state_e  frame FSM and receiver FSM encodings
// -----------------------------------------------------------------------------
package uart_prog_loader_pkg;

  localparam logic [7:0] HDR_BYTE               = 8'h5A;
  localparam int         DEFAULT_CLKS_PER_BIT   = 10417;
  localparam int         IMEM_ADDR_W            = 14;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_HDR,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } load_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // States in which a silent line eventually aborts the frame.
  function automatic logic is_timed_state(load_state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  // The CPU only runs when nothing was ever started or the image is complete.
  function automatic logic holds_cpu(load_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// -----------------------------------------------------------------------------
// uart_prog_loader_if
// Instruction-memory write port driven by the loader.
//   imem_we     write strobe, one cycle per word
//   imem_addr   word address (ADDR_W bits)
//   imem_wdata  32-bit word
// master: the loader (drives); slave: the instruction ROM write port.
// -----------------------------------------------------------------------------
interface uart_prog_loader_if
  import uart_prog_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);

endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a 2-flop input synchronizer.
//   clock, reset  system clock, synchronous active-high reset
//   rx            asynchronous serial input, idles high
//   byte_data     last received byte (valid while byte_valid is high)
//   byte_valid    1-cycle pulse at mid-stop-bit when the stop bit is 1
// A start bit is confirmed at half a bit time; data bits are then sampled
// every CLKS_PER_BIT cycles, LSB first. Bytes with a bad stop bit are dropped.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_reg;
  logic             rx_s;
  rx_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             valid_reg, valid_next;

  assign rx_s       = sync_reg[1];
  assign byte_data  = shift_reg;
  assign byte_valid = valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg    <= 2'b11;
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    valid_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          // A glitch that is gone by mid-bit is not a start bit.
          state_next   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) state_next = RX_STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            valid_next = 1'b1;
            state_next = RX_IDLE;
          end else begin
            // Framing error: wait for the line to recover so the low stop
            // bit is not mistaken for the next start bit.
            state_next = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) state_next = RX_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Loads a new program image over UART into the instruction ROM write port and
// holds the CPU in reset while loading.
//   clock, reset   system clock, synchronous active-high reset
//   start          1-cycle pulse: (re)enter load mode, abort any frame
//   rx             UART serial input (8N1)
//   imem           instruction-memory write port (master modport)
//   cpu_hold       high while loading or after an error (drives CPU reset)
//   load_done      sticky success flag
//   load_err       sticky failure flag
//   words_loaded   words written in the current or last frame
// Frame: 0x5A, LEN_LO, LEN_HI, 4*LEN little-endian data bytes, XOR checksum.
// -----------------------------------------------------------------------------
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                rx,
  uart_prog_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MAX_LEN = 32'd1 << ADDR_W;

  logic [7:0] byte_data;
  logic       byte_valid;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  load_state_e       state_reg, state_next;
  logic [15:0]       len_reg, len_next;
  logic [31:0]       word_reg, word_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [7:0]        csum_reg, csum_next;
  logic [ADDR_W:0]   words_reg, words_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              hold_reg, hold_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [15:0]       len_new;
  logic [31:0]       word_new;
  logic [ADDR_W:0]   words_inc;
  logic              timeout_hit;

  assign len_new     = {byte_data, len_reg[7:0]};
  // First byte of a word ends up in [7:0] after four right shifts.
  assign word_new    = {byte_data, word_reg[31:8]};
  assign words_inc   = words_reg + 1'b1;
  assign timeout_hit = is_timed_state(state_reg) && (to_cnt_reg == TO_LAST);

  assign imem.imem_we    = we_reg;
  assign imem.imem_addr  = addr_reg;
  assign imem.imem_wdata = wdata_reg;
  assign cpu_hold        = hold_reg;
  assign load_done       = done_reg;
  assign load_err        = err_reg;
  assign words_loaded    = words_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      csum_reg     <= '0;
      words_reg    <= '0;
      to_cnt_reg   <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      hold_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      word_reg     <= word_next;
      byte_idx_reg <= byte_idx_next;
      csum_reg     <= csum_next;
      words_reg    <= words_next;
      to_cnt_reg   <= to_cnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      hold_reg     <= hold_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    word_next     = word_reg;
    byte_idx_next = byte_idx_reg;
    csum_next     = csum_reg;
    words_next    = words_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    done_next     = done_reg;
    err_next      = err_reg;

    if (start) begin
      // start wins over a byte arriving in the same cycle.
      state_next    = ST_WAIT_HDR;
      words_next    = '0;
      byte_idx_next = '0;
      csum_next     = '0;
      done_next     = 1'b0;
      err_next      = 1'b0;
    end else begin
      case (state_reg)
        ST_WAIT_HDR: begin
          if (byte_valid && (byte_data == HDR_BYTE)) state_next = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (byte_valid) begin
            len_next   = {8'h00, byte_data};
            state_next = ST_LEN_HI;
          end else if (timeout_hit) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (byte_valid) begin
            len_next = len_new;
            if ((len_new == 16'd0) || ({16'd0, len_new} > MAX_LEN)) begin
              state_next = ST_ERR;
              err_next   = 1'b1;
            end else begin
              state_next = ST_DATA;
            end
          end else if (timeout_hit) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            word_next     = word_new;
            csum_next     = csum_reg ^ byte_data;
            byte_idx_next = byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              // Load the write port now so the strobe, address and data
              // are all registered in the single WRITE cycle.
              state_next = ST_WRITE;
              we_next    = 1'b1;
              addr_next  = words_reg[ADDR_W-1:0];
              wdata_next = word_new;
            end
          end else if (timeout_hit) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
        ST_WRITE: begin
          words_next = words_inc;
          state_next = (32'(words_inc) == 32'(len_reg)) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (byte_valid) begin
            if (byte_data == csum_reg) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_ERR;
              err_next   = 1'b1;
            end
          end else if (timeout_hit) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_ERR: begin
          state_next = state_reg;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    hold_next = holds_cpu(state_next);

    if (byte_valid || (state_next != state_reg)) to_cnt_next = '0;
    else if (is_timed_state(state_reg))          to_cnt_next = to_cnt_reg + 1'b1;
    else                                          to_cnt_next = '0;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;
  import uart_prog_loader_pkg::*;

  localparam int CPB = 8;
  localparam int AW  = 14;
  localparam int TO  = 2000;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  typedef wr_t wr_q_t[$];
  typedef struct {
    logic [15:0] len;
    bit          good_csum;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          rx;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  wr_q_t wr_q;

  uart_prog_loader_if #(.ADDR_W(AW)) imem_bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT  (CPB),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rx          (rx),
    .imem        (imem_bus),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  // Record every ROM write, sampled mid-cycle.
  always @(negedge clock) begin
    if (imem_bus.imem_we === 1'b1) wr_q.push_back('{addr: imem_bus.imem_addr, data: imem_bus.imem_wdata});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = good_stop;
    tick(CPB);
    rx = 1'b1;
    tick(good_stop ? 2 : 2 * CPB);
  endtask

  task automatic send_stream(input bq_t s);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Reference: parse a byte stream the way the frame format describes and
  // return the ROM writes it implies (data words present in the stream).
  function automatic wr_q_t model_writes(input bq_t s);
    wr_q_t       w;
    int          i;
    int          len;
    logic [31:0] word;
    w = {};
    i = 0;
    while (i < s.size() && s[i] != HDR_BYTE) i++;
    if (i + 2 >= s.size()) return w;
    len = int'(s[i+1]) + 256 * int'(s[i+2]);
    if (len == 0 || len > (1 << AW)) return w;
    i += 3;
    for (int n = 0; n < len; n++) begin
      if (i + 4 > s.size()) break;
      word = {s[i+3], s[i+2], s[i+1], s[i]};
      w.push_back('{addr: AW'(n), data: word});
      i += 4;
    end
    return w;
  endfunction

  // Random frame of nw words, preceded by one non-header garbage byte.
  function automatic bq_t make_frame(input logic [15:0] len, input int nw, input bit good);
    bq_t        s;
    logic [7:0] b;
    logic [7:0] cs;
    s = {};
    b = 8'($urandom_range(0, 255));
    if (b == HDR_BYTE) b = 8'h00;
    s.push_back(b);
    s.push_back(HDR_BYTE);
    s.push_back(len[7:0]);
    s.push_back(len[15:8]);
    if (nw > 0) begin
      cs = 8'h00;
      for (int k = 0; k < 4 * nw; k++) begin
        b = 8'($urandom_range(0, 255));
        s.push_back(b);
        cs ^= b;
      end
      s.push_back(good ? cs : ((cs == 8'hFF) ? 8'h00 : 8'hFF));
    end
    return s;
  endfunction

  task automatic compare_writes(input string tag, input wr_q_t exp_w);
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k < wr_q.size()) begin
        check({tag, "_addr"}, 64'(wr_q[k].addr), 64'(exp_w[k].addr));
        check({tag, "_data"}, 64'(wr_q[k].data), 64'(exp_w[k].data));
      end
    end
  endtask

  vec_t  vecs[9];
  bq_t   s;
  wr_q_t exp_w;
  int    waited;
  int    nw;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rx    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state.
    check("rst_hold",  64'(cpu_hold), 64'(0));
    check("rst_done",  64'(load_done), 64'(0));
    check("rst_err",   64'(load_err), 64'(0));
    check("rst_words", 64'(words_loaded), 64'(0));
    check("rst_we",    64'(imem_bus.imem_we), 64'(0));
    check("rst_addr",  64'(imem_bus.imem_addr), 64'(0));
    check("rst_wdata", 64'(imem_bus.imem_wdata), 64'(0));
    $display("reset: hold=%0b done=%0b err=%0b", cpu_hold, load_done, load_err);

    // Single word, fixed bytes; cpu_hold rises the cycle after start.
    pulse_start();
    check("start_hold", 64'(cpu_hold), 64'(1));
    wr_q.delete();
    s = '{8'h5A, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_stream(s);
    tick(2 * CPB);
    exp_w = '{'{addr: AW'(0), data: 32'h12345678}};
    compare_writes("single", exp_w);
    check("single_done",  64'(load_done), 64'(1));
    check("single_err",   64'(load_err), 64'(0));
    check("single_hold",  64'(cpu_hold), 64'(0));
    check("single_words", 64'(words_loaded), 64'(1));
    $display("single word: writes=%0d done=%0b hold=%0b", wr_q.size(), load_done, cpu_hold);

    // Restart from DONE: hold back up and flags cleared one cycle later.
    pulse_start();
    check("restart_hold", 64'(cpu_hold), 64'(1));
    check("restart_done", 64'(load_done), 64'(0));

    // Table of frames with random payloads.
    vecs[0] = '{len: 16'd1,      good_csum: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 16'd3,      good_csum: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 16'd2,      good_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{len: 16'd4,      good_csum: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{len: 16'd0,      good_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[5] = '{len: 16'h4001,   good_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    vecs[6] = '{len: 16'd5,      good_csum: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[7] = '{len: 16'd1,      good_csum: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[8] = '{len: 16'hFFFF,   good_csum: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

    for (int v = 0; v < 9; v++) begin
      nw = (vecs[v].len == 16'd0 || int'(vecs[v].len) > (1 << AW)) ? 0 : int'(vecs[v].len);
      s = make_frame(vecs[v].len, nw, vecs[v].good_csum);
      exp_w = model_writes(s);
      pulse_start();
      wr_q.delete();
      send_stream(s);
      tick(2 * CPB);
      compare_writes($sformatf("vec%0d", v), exp_w);
      check($sformatf("vec%0d_done", v),  64'(load_done), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v),   64'(load_err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_hold", v),  64'(cpu_hold), 64'(!vecs[v].exp_done));
      check($sformatf("vec%0d_words", v), 64'(words_loaded), 64'(exp_w.size()));
      $display("vec %0d: len=0x%0h writes=%0d done=%0b err=%0b", v, vecs[v].len, wr_q.size(), load_done, load_err);
    end

    // A byte with a bad stop bit is dropped; the frame still completes.
    pulse_start();
    wr_q.delete();
    s = '{8'h5A, 8'h01, 8'h00};
    send_stream(s);
    send_byte(8'h33, 1'b0);
    s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_stream(s);
    tick(2 * CPB);
    exp_w = '{'{addr: AW'(0), data: 32'h44332211}};
    compare_writes("framing", exp_w);
    check("framing_done", 64'(load_done), 64'(1));
    $display("framing error: writes=%0d done=%0b", wr_q.size(), load_done);

    // Timeout after two data bytes.
    pulse_start();
    wr_q.delete();
    s = '{8'h5A, 8'h02, 8'h00, 8'hAA, 8'hBB};
    send_stream(s);
    tick(TO - 20);
    check("to_early_err", 64'(load_err), 64'(0));
    waited = 0;
    while (load_err !== 1'b1 && waited < 60) begin
      tick(1);
      waited++;
    end
    check("to_err",    64'(load_err), 64'(1));
    check("to_hold",   64'(cpu_hold), 64'(1));
    check("to_done",   64'(load_done), 64'(0));
    check("to_writes", 64'(wr_q.size()), 64'(0));
    $display("timeout: err=%0b after %0d extra cycles", load_err, waited);

    // Resync: garbage before a valid frame is ignored.
    pulse_start();
    wr_q.delete();
    s = '{8'h00, 8'h11};
    send_stream(s);
    s = make_frame(16'd2, 2, 1'b1);
    exp_w = model_writes(s);
    send_stream(s);
    tick(2 * CPB);
    compare_writes("resync", exp_w);
    check("resync_done", 64'(load_done), 64'(1));
    $display("resync: writes=%0d done=%0b", wr_q.size(), load_done);

    // Abort mid-DATA with start; next frame writes from address 0.
    pulse_start();
    s = make_frame(16'd2, 2, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(s[i], 1'b1);
    check("abort_mid_words", 64'(words_loaded), 64'(1));
    pulse_start();
    check("abort_done",  64'(load_done), 64'(0));
    check("abort_err",   64'(load_err), 64'(0));
    check("abort_hold",  64'(cpu_hold), 64'(1));
    check("abort_words", 64'(words_loaded), 64'(0));
    wr_q.delete();
    s = make_frame(16'd1, 1, 1'b1);
    exp_w = model_writes(s);
    send_stream(s);
    tick(2 * CPB);
    compare_writes("abort", exp_w);
    check("abort_final_done", 64'(load_done), 64'(1));
    $display("abort: writes=%0d done=%0b", wr_q.size(), load_done);

    // Reset in the middle of a frame.
    pulse_start();
    s = make_frame(16'd3, 3, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(s[i], 1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("mrst_hold",  64'(cpu_hold), 64'(0));
    check("mrst_done",  64'(load_done), 64'(0));
    check("mrst_err",   64'(load_err), 64'(0));
    check("mrst_words", 64'(words_loaded), 64'(0));
    check("mrst_we",    64'(imem_bus.imem_we), 64'(0));
    check("mrst_addr",  64'(imem_bus.imem_addr), 64'(0));
    check("mrst_wdata", 64'(imem_bus.imem_wdata), 64'(0));
    $display("reset mid-frame: hold=%0b words=%0d", cpu_hold, words_loaded);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
